// File: rtl/pc_register_unit.sv
// Program counter and next-PC select for the single-cycle MIPS core.
// Stall, halt and misaligned-jr trap control with a saturating fetch counter.
module pc_register_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          COUNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jr,
  input  logic               halt,
  input  logic [31:0]        imm_ext,
  input  logic [25:0]        jump_index,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        PC_plus4_in,
  output logic [31:0]        PC_out,
  output logic               running,
  output logic               trap_out,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    TRAP   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_n;
  logic [COUNT_W-1:0]   r_cnt;
  logic [COUNT_W-1:0]   w_cnt_n;
  logic                 w_adv;
  logic [31:0]          w_br_tgt;
  logic [31:0]          w_j_tgt;
  logic                 w_unused_imm;

  assign w_br_tgt = PC_plus4_in + {imm_ext[29:0], 2'b00};
  assign w_j_tgt  = {PC_plus4_in[31:28], jump_index, 2'b00};
  assign w_unused_imm = ^imm_ext[31:30];

  // Next state, next PC and advance decision in priority order
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_adv     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (halt) begin
          w_state_n = HALTED;
        end else if (!stall) begin
          if (jr) begin
            if (rs_data[1:0] != 2'b00) begin
              w_state_n = TRAP;
              w_pc_n    = EXC_VECTOR;
            end else begin
              w_pc_n = rs_data;
              w_adv  = 1'b1;
            end
          end else if (jump) begin
            w_pc_n = w_j_tgt;
            w_adv  = 1'b1;
          end else if (branch_taken) begin
            w_pc_n = w_br_tgt;
            w_adv  = 1'b1;
          end else begin
            w_pc_n = PC_plus4_in;
            w_adv  = 1'b1;
          end
        end
      end
      TRAP: begin
        w_pc_n = EXC_VECTOR;
      end
      HALTED: begin
        w_pc_n = r_pc;
      end
      default: begin
        w_state_n = TRAP;
        w_pc_n    = EXC_VECTOR;
      end
    endcase
  end

  // Fetch counter stops at all-ones instead of wrapping
  always_comb begin
    w_cnt_n = r_cnt;
    if (w_adv && (r_cnt != {COUNT_W{1'b1}})) begin
      w_cnt_n = r_cnt + 1'b1;
    end
  end

  // State, PC and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign PC_out      = r_pc;
  assign fetch_count = r_cnt;
  assign running     = (r_state == RUN);
  assign trap_out    = (r_state == TRAP);

endmodule

// File: tb/tb_pc_register_unit.sv
// Directed bench for pc_register_unit with a behavioural reference model.
// Narrow counter instance so saturation is reachable.
module tb_pc_register_unit;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset, stall, branch_taken, jump, jr, halt;
  logic [31:0]   imm_ext, rs_data, PC_plus4_in, PC_out;
  logic [25:0]   jump_index;
  logic          running, trap_out;
  logic [CW-1:0] fetch_count;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // model: mode 0=run 1=halted 2=trap
  logic [31:0] m_pc;
  int          m_cnt;
  int          m_mode;

  always #5 clock = ~clock;

  assign PC_plus4_in = PC_out + 32'd4;

  pc_register_unit #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080),
    .COUNT_W   (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .branch_taken(branch_taken),
    .jump        (jump),
    .jr          (jr),
    .halt        (halt),
    .imm_ext     (imm_ext),
    .jump_index  (jump_index),
    .rs_data     (rs_data),
    .PC_plus4_in (PC_plus4_in),
    .PC_out      (PC_out),
    .running     (running),
    .trap_out    (trap_out),
    .fetch_count (fetch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: what the next PC must be, from the rules
  task automatic model_update();
    logic [31:0] p4;
    bit adv;
    p4 = m_pc + 32'd4;
    adv = 0;
    if (reset) begin
      m_pc = 32'h0; m_cnt = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (halt) m_mode = 1;
      else if (!stall) begin
        adv = 1;
        if (jr) begin
          if (rs_data % 4 != 0) begin
            m_mode = 2; m_pc = 32'h80; adv = 0;
          end else m_pc = rs_data;
        end else if (jump)
          m_pc = (p4 & 32'hF000_0000) | (32'(jump_index) * 4);
        else if (branch_taken)
          m_pc = p4 + imm_ext * 4;
        else
          m_pc = p4;
      end
      if (adv && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  task automatic step(input logic rst, st, br, jp, j_r, hl,
                      input logic [31:0] imm, input logic [25:0] ji,
                      input logic [31:0] rs);
    @(negedge clock);
    reset = rst; stall = st; branch_taken = br; jump = jp;
    jr = j_r; halt = hl; imm_ext = imm; jump_index = ji; rs_data = rs;
    @(posedge clock);
    #1;
    model_update();
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,0,0,32'h0,26'h0,32'h0);
  endtask

  task automatic do_jr(input logic [31:0] rs);
    step(0,0,0,0,1,0,32'h0,26'h0,rs);
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc_model", PC_out, m_pc);
      chk("cnt_model", 32'(fetch_count), 32'(m_cnt));
      chk("run_model", 32'(running), 32'(m_mode == 0));
      chk("trap_model", 32'(trap_out), 32'(m_mode == 2));
    end
  end

  initial begin
    m_pc = 0; m_cnt = 0; m_mode = 0;
    reset = 1; stall = 0; branch_taken = 0; jump = 0; jr = 0; halt = 0;
    imm_ext = 0; jump_index = 0; rs_data = 0;
    step(1,0,0,0,0,0,32'h0,26'h0,32'h0);
    step(1,0,0,0,0,0,32'h0,26'h0,32'h0);
    chk_en = 1'b1;
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_cnt", 32'(fetch_count), 32'd0);
    chk("rst_run", 32'(running), 32'd1);
    chk("rst_trap", 32'(trap_out), 32'd0);
    // T1
    free(3);
    chk("t1_pc", PC_out, 32'd12);
    chk("t1_cnt", 32'(fetch_count), 32'd3);
    // T2
    free(1);
    chk("t2_pre", PC_out, 32'h10);
    step(0,0,1,0,0,0,32'hFFFF_FFFC,26'h0,32'h0);
    chk("t2_pc", PC_out, 32'h04);
    // T3
    do_jr(32'h3000_0000);
    step(0,0,1,1,0,0,32'h0000_0010,26'h0000040,32'h0);
    chk("t3_pc", PC_out, 32'h3000_0100);
    chk("t3_cnt", 32'(fetch_count), 32'd7);
    // PC+4 wrap and branch carry wrap
    do_jr(32'hFFFF_FFFC);
    free(1);
    chk("wrap_pc", PC_out, 32'h0);
    step(0,0,1,0,0,0,32'h1,26'h0,32'h0);
    chk("br_fwd", PC_out, 32'h8);
    do_jr(32'hFFFF_FFF0);
    step(0,0,1,0,0,0,32'h8,26'h0,32'h0);
    chk("br_wrap", PC_out, 32'h14);
    // jr beats jump and branch
    step(0,0,1,1,1,0,32'h4,26'h3,32'h100);
    chk("jr_prio", PC_out, 32'h100);
    // T5
    do_jr(32'h20);
    step(0,1,0,1,0,0,32'h0,26'h100,32'h0);
    step(0,1,0,1,0,0,32'h0,26'h100,32'h0);
    chk("t5_hold", PC_out, 32'h20);
    chk("t5_cnt", 32'(fetch_count), 32'd14);
    step(0,0,0,1,0,0,32'h0,26'h100,32'h0);
    chk("t5_jump", PC_out, 32'h400);
    free(2);
    chk("sat_cnt", 32'(fetch_count), 32'd15);
    // T6
    step(0,1,1,1,0,1,32'h4,26'h5,32'h0);
    chk("t6_run", 32'(running), 32'd0);
    chk("t6_pc", PC_out, 32'h408);
    step(0,0,0,1,1,0,32'h0,26'h5,32'h44);
    free(1);
    chk("t6_frozen", PC_out, 32'h408);
    step(1,0,0,1,0,1,32'h0,26'h5,32'h0);
    chk("t6_rst_pc", PC_out, 32'h0);
    chk("t6_rst_run", 32'(running), 32'd1);
    chk("t6_rst_cnt", 32'(fetch_count), 32'd0);
    // T4
    free(1);
    do_jr(32'h42);
    chk("t4_pc", PC_out, 32'h80);
    chk("t4_trap", 32'(trap_out), 32'd1);
    step(0,0,0,1,0,0,32'h0,26'h9,32'h0);
    free(1);
    chk("t4_hold", PC_out, 32'h80);
    chk("t4_cnt", 32'(fetch_count), 32'd1);
    step(1,0,0,0,0,0,32'h0,26'h0,32'h0);
    chk("t4_rst_trap", 32'(trap_out), 32'd0);
    chk("t4_rst_pc", PC_out, 32'h0);
    free(1);
    @(negedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
